// File: rtl/auto_paddles_pkg.sv
// Shared definitions for the paddle movement block and the game-control FSM.
package auto_paddles_pkg;

   // Per-paddle movement mode; the reserved code behaves as HOLD.
   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_SWEEP = 2'd1,
      MODE_TRACK = 2'd2,
      MODE_RSVD  = 2'd3
   } pad_mode_e;

   // Prescaler counter width; a divide-by-one still needs one bit of state.
   function automatic int cnt_width(input int div);
      if (div > 1) begin
         return $clog2(div);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/paddle_mover.sv
// One paddle: position and heading, updated on each movement tick.
module paddle_mover
   import auto_paddles_pkg::*;
#(
   parameter int   Y_W        = 11,
   parameter int   Y_MIN      = 62,
   parameter int   Y_MAX      = 418,
   parameter int   STEP       = 1,
   parameter logic START_HIGH = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick,
   input  pad_mode_e      mode,
   input  logic [Y_W-1:0] target,
   input  logic           target_vld,
   output logic [Y_W-1:0] p_y,
   output logic           at_edge
);

   // One extra bit so sums and differences never wrap before clamping.
   localparam int             X_W        = Y_W + 1;
   localparam logic [X_W-1:0] MIN_X      = X_W'(Y_MIN);
   localparam logic [X_W-1:0] MAX_X      = X_W'(Y_MAX);
   localparam logic [X_W-1:0] STEP_X     = X_W'(STEP);
   localparam logic [X_W-1:0] MIN_STEP_X = X_W'(Y_MIN + STEP);
   localparam logic [X_W-1:0] MAX_STEP_X = X_W'(Y_MAX - STEP);
   localparam logic [Y_W-1:0] RST_Y      = START_HIGH ? Y_W'(Y_MAX) : Y_W'(Y_MIN);

   logic [Y_W-1:0] p_y_r;
   logic           dir_dn_r;
   logic           at_edge_r;
   logic [X_W-1:0] pos_x_s;
   logic [X_W-1:0] tgt_x_s;
   logic [X_W-1:0] nxt_x_s;
   logic           nxt_dn_s;

   // Next position/heading for the current mode, applied only on a tick.
   always_comb begin
      pos_x_s  = {1'b0, p_y_r};
      tgt_x_s  = {1'b0, target};
      nxt_x_s  = pos_x_s;
      nxt_dn_s = dir_dn_r;
      case (mode)
         MODE_SWEEP: begin
            if (pos_x_s < MIN_X) begin
               nxt_x_s  = MIN_X;
               nxt_dn_s = 1'b1;
            end else if (pos_x_s > MAX_X) begin
               nxt_x_s  = MAX_X;
               nxt_dn_s = 1'b0;
            end else if (dir_dn_r) begin
               if (pos_x_s == MAX_X) begin
                  nxt_x_s  = MAX_STEP_X;
                  nxt_dn_s = 1'b0;
               end else if ((pos_x_s + STEP_X) > MAX_X) begin
                  nxt_x_s  = MAX_X;
                  nxt_dn_s = 1'b0;
               end else begin
                  nxt_x_s  = pos_x_s + STEP_X;
                  nxt_dn_s = 1'b1;
               end
            end else begin
               if (pos_x_s == MIN_X) begin
                  nxt_x_s  = MIN_STEP_X;
                  nxt_dn_s = 1'b1;
               end else if (pos_x_s < MIN_STEP_X) begin
                  nxt_x_s  = MIN_X;
                  nxt_dn_s = 1'b1;
               end else begin
                  nxt_x_s  = pos_x_s - STEP_X;
                  nxt_dn_s = 1'b0;
               end
            end
         end
         MODE_TRACK: begin
            if (!target_vld) begin
               nxt_x_s  = pos_x_s;
               nxt_dn_s = dir_dn_r;
            end else if (pos_x_s < MIN_X) begin
               nxt_x_s  = MIN_X;
               nxt_dn_s = 1'b1;
            end else if (pos_x_s > MAX_X) begin
               nxt_x_s  = MAX_X;
               nxt_dn_s = 1'b0;
            end else if (tgt_x_s > pos_x_s) begin
               if ((tgt_x_s - pos_x_s) > STEP_X) begin
                  nxt_x_s = pos_x_s + STEP_X;
               end else begin
                  nxt_x_s = tgt_x_s;
               end
               nxt_dn_s = 1'b1;
            end else if (tgt_x_s < pos_x_s) begin
               if ((pos_x_s - tgt_x_s) > STEP_X) begin
                  nxt_x_s = pos_x_s - STEP_X;
               end else begin
                  nxt_x_s = tgt_x_s;
               end
               nxt_dn_s = 1'b0;
            end else begin
               nxt_x_s  = pos_x_s;
               nxt_dn_s = dir_dn_r;
            end
         end
         default: begin
            nxt_x_s  = pos_x_s;
            nxt_dn_s = dir_dn_r;
         end
      endcase
   end

   // Position, heading and edge flag; reset wins over a coincident tick.
   always_ff @(posedge clk) begin
      if (!rst) begin
         p_y_r     <= RST_Y;
         dir_dn_r  <= ~START_HIGH;
         at_edge_r <= 1'b1;
      end else if (tick) begin
         p_y_r     <= nxt_x_s[Y_W-1:0];
         dir_dn_r  <= nxt_dn_s;
         at_edge_r <= (nxt_x_s == MIN_X) || (nxt_x_s == MAX_X);
      end
   end

   assign p_y     = p_y_r;
   assign at_edge = at_edge_r;

endmodule

// File: rtl/auto_paddles.sv
// Automatic paddle driver: shared tick prescaler and ball clamp, one mover per paddle.
module auto_paddles
   import auto_paddles_pkg::*;
#(
   parameter int N_PAD    = 2,
   parameter int Y_W      = 11,
   parameter int Y_MIN    = 62,
   parameter int Y_MAX    = 418,
   parameter int TICK_DIV = 262144,
   parameter int STEP     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2*N_PAD-1:0]   mode,
   input  logic [Y_W-1:0]       ball_y,
   input  logic                 ball_vld,
   output logic [Y_W*N_PAD-1:0] p_y,
   output logic [N_PAD-1:0]     at_edge,
   output logic                 tick
);

   localparam int             CNT_W    = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);

   logic [CNT_W-1:0] cnt_r;
   logic             tick_s;
   logic [Y_W-1:0]   target_s;

   // Tick fires on the last count of an enabled cycle; suppressed while in reset.
   always_comb begin
      tick_s = en && rst && (cnt_r == CNT_LAST);
   end

   // Prescaler: counts enabled cycles, wraps at TICK_DIV, freezes when disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (en) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Ball position limited to the paddle travel range, shared by all trackers.
   always_comb begin
      target_s = ball_y;
      if (ball_y < Y_MIN_V) begin
         target_s = Y_MIN_V;
      end else if (ball_y > Y_MAX_V) begin
         target_s = Y_MAX_V;
      end else begin
         target_s = ball_y;
      end
   end

   assign tick = tick_s;

   for (genvar i = 0; i < N_PAD; i++) begin : g_pad
      paddle_mover #(
         .Y_W        (Y_W),
         .Y_MIN      (Y_MIN),
         .Y_MAX      (Y_MAX),
         .STEP       (STEP),
         .START_HIGH (1'(i % 2))
      ) u_mover (
         .clk        (clk),
         .rst        (rst),
         .tick       (tick_s),
         .mode       (pad_mode_e'(mode[2*i +: 2])),
         .target     (target_s),
         .target_vld (ball_vld),
         .p_y        (p_y[Y_W*i +: Y_W]),
         .at_edge    (at_edge[i])
      );
   end

endmodule

// File: tb/tb_auto_paddles.sv
// Self-checking bench for auto_paddles with TICK_DIV=4, STEP=3.
module tb_auto_paddles;

   localparam int N_PAD    = 2;
   localparam int Y_W      = 11;
   localparam int Y_MIN    = 62;
   localparam int Y_MAX    = 418;
   localparam int TICK_DIV = 4;
   localparam int STEP     = 3;

   localparam logic [1:0] HD = 2'd0;
   localparam logic [1:0] SW = 2'd1;
   localparam logic [1:0] TR = 2'd2;
   localparam logic [1:0] RS = 2'd3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [2*N_PAD-1:0]   mode;
   logic [Y_W-1:0]       ball_y;
   logic                 ball_vld;
   logic [Y_W*N_PAD-1:0] p_y;
   logic [N_PAD-1:0]     at_edge;
   logic                 tick;

   auto_paddles #(
      .N_PAD    (N_PAD),
      .Y_W      (Y_W),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX),
      .TICK_DIV (TICK_DIV),
      .STEP     (STEP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .ball_y   (ball_y),
      .ball_vld (ball_vld),
      .p_y      (p_y),
      .at_edge  (at_edge),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int e0;
      int e1;
   } exp_t;

   typedef struct {
      logic [1:0] m0;
      logic [1:0] m1;
      int         by;
      logic       bv;
      int         e0;
      int         e1;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[11];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_pos[2];
   bit   m_dn[2];

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   function automatic int edge_of(input int a, input int b);
      int r;
      r = 0;
      if (a == Y_MIN || a == Y_MAX) r = r + 1;
      if (b == Y_MIN || b == Y_MAX) r = r + 2;
      return r;
   endfunction

   task automatic model_reset();
      m_pos[0] = Y_MIN;
      m_dn[0]  = 1'b1;
      m_pos[1] = Y_MAX;
      m_dn[1]  = 1'b0;
   endtask

   // Tick-level reference of one movement update for both paddles.
   task automatic model_step(input logic [1:0] m0, input logic [1:0] m1, input int by, input logic bv);
      int         t;
      logic [1:0] md;
      t = (by < Y_MIN) ? Y_MIN : ((by > Y_MAX) ? Y_MAX : by);
      for (int i = 0; i < 2; i++) begin
         md = (i == 0) ? m0 : m1;
         if (md == SW) begin
            if (m_dn[i]) begin
               if (m_pos[i] >= Y_MAX) begin
                  m_pos[i] = Y_MAX - STEP;
                  m_dn[i]  = 1'b0;
               end else begin
                  m_pos[i] = m_pos[i] + STEP;
                  if (m_pos[i] > Y_MAX) begin
                     m_pos[i] = Y_MAX;
                     m_dn[i]  = 1'b0;
                  end
               end
            end else begin
               if (m_pos[i] <= Y_MIN) begin
                  m_pos[i] = Y_MIN + STEP;
                  m_dn[i]  = 1'b1;
               end else begin
                  m_pos[i] = m_pos[i] - STEP;
                  if (m_pos[i] < Y_MIN) begin
                     m_pos[i] = Y_MIN;
                     m_dn[i]  = 1'b1;
                  end
               end
            end
         end else if (md == TR && bv) begin
            if (t > m_pos[i]) begin
               m_pos[i] = m_pos[i] + (((t - m_pos[i]) < STEP) ? (t - m_pos[i]) : STEP);
               m_dn[i]  = 1'b1;
            end else if (t < m_pos[i]) begin
               m_pos[i] = m_pos[i] - (((m_pos[i] - t) < STEP) ? (m_pos[i] - t) : STEP);
               m_dn[i]  = 1'b0;
            end
         end
      end
   endtask

   // Waits (bounded) for a negedge with tick high; k = negedges waited, 0 on timeout.
   task automatic wait_tick(output int k);
      bit done;
      k    = 0;
      done = 1'b0;
      for (int c = 1; c <= 16 && !done; c++) begin
         @(negedge clk);
         if (tick) begin
            k    = c;
            done = 1'b1;
         end
      end
   endtask

   // Drive one tick's inputs, queue its expectation, compare after the update edge.
   task automatic do_tick(input logic [1:0] m0, input logic [1:0] m1, input int by, input logic bv,
                          input int e0, input int e1, input int exp_k, input string nm);
      exp_t e;
      int   k;
      mode     = {m1, m0};
      ball_y   = Y_W'(by);
      ball_vld = bv;
      sb_q.push_back('{e0, e1});
      wait_tick(k);
      if (k == 0) begin
         n_checks++;
         $display("FAIL %s tick timeout: no tick within 16 cycles, expected after %0d", nm, exp_k);
      end else begin
         chk({nm, " tick interval"}, k, exp_k);
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk({nm, " p0"}, int'(p_y[Y_W-1:0]), e.e0);
      chk({nm, " p1"}, int'(p_y[2*Y_W-1:Y_W]), e.e1);
      chk({nm, " at_edge"}, int'(at_edge), edge_of(e.e0, e.e1));
   endtask

   task automatic apply_rows(input int lo, input int hi);
      for (int r = lo; r <= hi; r++) begin
         model_step(vecs[r].m0, vecs[r].m1, vecs[r].by, vecs[r].bv);
         do_tick(vecs[r].m0, vecs[r].m1, vecs[r].by, vecs[r].bv,
                 vecs[r].e0, vecs[r].e1, 4, $sformatf("vec%0d", r));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;

      // Hand-computed tick vectors: {mode0, mode1, ball_y, ball_vld, p0, p1}.
      vecs[0]  = '{SW, SW, 0,   1'b0, 415, 65};
      vecs[1]  = '{TR, HD, 105, 1'b1, 103, 65};
      vecs[2]  = '{TR, HD, 105, 1'b1, 105, 65};
      vecs[3]  = '{TR, HD, 105, 1'b1, 105, 65};
      vecs[4]  = '{TR, HD, 300, 1'b0, 105, 65};
      vecs[5]  = '{TR, SW, 200, 1'b1, 65,  68};
      vecs[6]  = '{SW, HD, 0,   1'b1, 68,  68};
      vecs[7]  = '{TR, RS, 60,  1'b1, 65,  68};
      vecs[8]  = '{SW, HD, 0,   1'b1, 62,  68};
      vecs[9]  = '{SW, SW, 0,   1'b1, 65,  71};
      vecs[10] = '{HD, SW, 0,   1'b1, 65,  74};

      rst      = 1'b0;
      en       = 1'b1;
      mode     = {SW, SW};
      ball_y   = '0;
      ball_vld = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset p0", int'(p_y[Y_W-1:0]), 62);
      chk("reset p1", int'(p_y[2*Y_W-1:Y_W]), 418);
      chk("reset at_edge", int'(at_edge), 3);
      chk("reset tick", int'(tick), 0);

      // Release and sweep both paddles 119 ticks.
      rst = 1'b1;
      model_reset();
      for (int n = 1; n <= 119; n++) begin
         model_step(SW, SW, 0, 1'b0);
         do_tick(SW, SW, 0, 1'b0, m_pos[0], m_pos[1], (n == 1) ? 3 : 4, $sformatf("sweep%0d", n));
      end
      chk("sweep119 p0 at bottom", int'(p_y[Y_W-1:0]), 418);
      chk("sweep119 at_edge0", int'(at_edge[0]), 1);

      // Bounce off the bottom limit.
      apply_rows(0, 0);

      // Track down to ball_y=100 while paddle 1 holds.
      for (int n = 1; n <= 105; n++) begin
         model_step(TR, HD, 100, 1'b1);
         do_tick(TR, HD, 100, 1'b1, m_pos[0], m_pos[1], 4, $sformatf("track100_%0d", n));
      end
      chk("track reached 100", int'(p_y[Y_W-1:0]), 100);

      apply_rows(1, 4);

      // Ball above the travel range: target clamps to the top limit.
      for (int n = 1; n <= 15; n++) begin
         model_step(TR, HD, 20, 1'b1);
         do_tick(TR, HD, 20, 1'b1, m_pos[0], m_pos[1], 4, $sformatf("track20_%0d", n));
      end
      chk("track clamp p0", int'(p_y[Y_W-1:0]), 62);
      chk("track clamp at_edge0", int'(at_edge[0]), 1);

      // Heading inherited from tracking, reserved mode, mixed modes.
      apply_rows(5, 10);

      // Enable dropped mid-count: frozen, then resumes from held count.
      repeat (2) @(negedge clk);
      en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("en_off%0d tick", c), int'(tick), 0);
         chk($sformatf("en_off%0d p0", c), int'(p_y[Y_W-1:0]), 65);
         chk($sformatf("en_off%0d p1", c), int'(p_y[2*Y_W-1:Y_W]), 74);
      end
      en = 1'b1;
      model_step(HD, SW, 0, 1'b1);
      do_tick(HD, SW, 0, 1'b1, 65, 77, 2, "en_resume");

      // Reset asserted in a tick cycle overrides the movement.
      mode = {SW, SW};
      wait_tick(k);
      if (k == 0) begin
         n_checks++;
         $display("FAIL rst_on_tick: no tick within 16 cycles, expected after 4");
      end else begin
         chk("rst_on_tick interval", k, 4);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_on_tick p0", int'(p_y[Y_W-1:0]), 62);
      chk("rst_on_tick p1", int'(p_y[2*Y_W-1:Y_W]), 418);
      chk("rst_on_tick at_edge", int'(at_edge), 3);
      chk("rst_on_tick tick", int'(tick), 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      model_step(SW, SW, 0, 1'b0);
      do_tick(SW, SW, 0, 1'b0, 65, 415, 3, "post_reset");

      chk("scoreboard drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/auto_paddles.md
AUTO_PADDLES -- requirements
Module: auto_paddles

Interface
REQ-001 Parameter N_PAD, default 2: number of independently driven paddles, 1..8.
REQ-002 Parameter Y_W, default 11: width of every vertical coordinate.
REQ-003 Parameter Y_MIN, default 62: top travel limit, inclusive.
REQ-004 Parameter Y_MAX, default 418: bottom travel limit, inclusive; Y_MIN < Y_MAX < 2^Y_W.
REQ-005 Parameter TICK_DIV, default 262144: clk cycles per movement tick, at least 1.
REQ-006 Parameter STEP, default 1: maximum pixels moved per tick, 1 <= STEP <= Y_MAX-Y_MIN.
REQ-007 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: reset, synchronous and active-low.
REQ-009 Port en, input, 1: high = prescaler runs; low = prescaler and all positions freeze.
REQ-010 Port mode, input, 2*N_PAD: 2-bit mode per paddle, slice i = bits [2i+1:2i].
REQ-011 Port ball_y, input, Y_W: ball vertical position, used as the target in TRACK mode.
REQ-012 Port ball_vld, input, 1: ball_y valid; when low, TRACK paddles hold position.
REQ-013 Port p_y, output, Y_W*N_PAD: paddle positions, slice i = paddle i, registered.
REQ-014 Port at_edge, output, N_PAD: bit i high while p_y[i] equals Y_MIN or Y_MAX, registered.
REQ-015 Port tick, output, 1: one-cycle pulse on each cycle in which a movement update is applied.

Function
REQ-016 Mode encoding: 0 = HOLD, 1 = SWEEP, 2 = TRACK, 3 = HOLD (reserved).
REQ-017 The prescaler counts 0..TICK_DIV-1 while en=1, then wraps to 0; the tick is asserted in the cycle the count equals TICK_DIV-1 and en=1.
REQ-018 The position update and the tick pulse occur in the same cycle; the new p_y is visible the cycle after the tick.
REQ-019 With en=0 the prescaler holds its value, no tick is produced and every p_y holds; mode/ball changes are not buffered.
REQ-020 HOLD: p_y[i] and heading[i] are unchanged on a tick.
REQ-021 SWEEP: on a tick, p_y[i] moves by STEP in the direction of heading[i] (down = +, up = -).
REQ-022 SWEEP: if the move would pass a limit, p_y[i] is clamped to that limit and heading[i] is inverted in the same tick.
REQ-023 SWEEP: a paddle already at a limit with heading pointing outward inverts heading and moves STEP inward on that tick.
REQ-024 TRACK: target = ball_y clamped to [Y_MIN, Y_MAX]; on a tick p_y[i] moves toward the target by min(STEP, |target - p_y[i]|).
REQ-025 TRACK: heading[i] is updated to the sign of the last non-zero move, so a later SWEEP continues in that direction.
REQ-026 Mode changes take effect at the next tick; mixed modes across paddles are legal simultaneously.
REQ-027 All arithmetic uses Y_W+1 bits internally so underflow below 0 and overflow above 2^Y_W-1 cannot wrap before clamping.
REQ-028 A p_y value outside the limits (only reachable through a parameter edge case) is clamped into range on the next tick in any non-HOLD mode.

Reset
REQ-029 While rst=0 at a clock edge: prescaler = 0, tick = 0.
REQ-030 Reset positions: even-index paddles go to Y_MIN with heading down; odd-index paddles go to Y_MAX with heading up.
REQ-031 Reset values: at_edge is all-ones, matching the reset positions.
REQ-032 Reset asserted mid-tick overrides the update in that cycle; the first post-reset tick comes TICK_DIV enabled cycles after release.

Structure
REQ-033 The mode encodings (HOLD/SWEEP/TRACK) are a shared-package enum, reused by the game-control FSM.
REQ-034 One sub-module, paddle_mover, is instantiated N_PAD times via generate; it holds one paddle's position/heading and takes tick, mode and target.
REQ-035 The prescaler and the ball_y clamp are single shared instances in auto_paddles.

Verification (TICK_DIV=4, STEP=3, defaults otherwise)
REQ-036 Reset release, en=1, both paddles SWEEP -> tick every 4th cycle; after tick 1, p_y = {415, 65}; after 119 ticks, p0 = 418 and at_edge[0] = 1.
REQ-037 p0=416, heading down, SWEEP tick -> p0 = 418 and heading up; next tick -> 415.
REQ-038 TRACK, p0=100, ball_y=105, ball_vld=1 -> 103 then 105 then 105; with ball_y=20 the target clamps and p0 settles at 62.
REQ-039 en dropped for 10 cycles mid-count -> no tick, p_y stable, prescaler resumes from its held value.
REQ-040 Mode HOLD on p1 with SWEEP on p0 -> p1 constant and p0 moving; ball_vld=0 in TRACK -> hold.
REQ-041 rst=0 on a tick cycle -> reset values of REQ-029 to REQ-031 are present the next cycle, with no movement applied.
